// File: rtl/alu_slice_sequencer_pkg.sv
// Shared constants, state encoding and slice-select helpers for the ALU slice sequencer.
package alu_slice_sequencer_pkg;

   localparam int unsigned WF_LANES    = 64;
   localparam int unsigned SLICE_LANES = 16;
   localparam int unsigned NUM_SLICES  = 4;
   localparam int unsigned LANE_BITS   = 32;
   localparam int unsigned VEC_BITS    = WF_LANES * LANE_BITS;
   localparam int unsigned SLICE_BITS  = SLICE_LANES * LANE_BITS;

   localparam logic [1:0] LAST_SLICE = 2'(NUM_SLICES - 1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } seq_state_e;

   function automatic logic [SLICE_BITS-1:0] vec_slice(input logic [VEC_BITS-1:0] vec,
                                                      input logic [1:0] k);
      return vec[k*SLICE_BITS +: SLICE_BITS];
   endfunction

   function automatic logic [SLICE_LANES-1:0] mask_slice(input logic [WF_LANES-1:0] mask,
                                                        input logic [1:0] k);
      return mask[k*SLICE_LANES +: SLICE_LANES];
   endfunction

endpackage

// File: rtl/slice_valid_pipe.sv
// Fixed-depth shift register tracking issued slices through the ALU pipeline.
module slice_valid_pipe #(
   parameter int unsigned DEPTH = 4
) (
   input  logic i_clk,
   input  logic i_clr,
   input  logic i_valid,
   output logic o_valid
);

   logic [DEPTH-1:0] r_pipe;

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_pipe <= '0;
      end else begin
         r_pipe[0] <= i_valid;
         for (int i = 1; i < int'(DEPTH); i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign o_valid = r_pipe[DEPTH-1];

endmodule

// File: rtl/alu_slice_sequencer.sv
// Splits a 64-lane operand set into four 16-lane ALU slices and sequences dest-buffer writes.
module alu_slice_sequencer
   import alu_slice_sequencer_pkg::*;
#(
   parameter int unsigned ALU_LATENCY = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_issue_valid,
   output logic                   o_issue_ready,
   input  logic [VEC_BITS-1:0]    i_src0_data,
   input  logic [VEC_BITS-1:0]    i_src1_data,
   input  logic [VEC_BITS-1:0]    i_src2_data,
   input  logic [WF_LANES-1:0]    i_exec_value,
   input  logic [WF_LANES-1:0]    i_vcc_value,
   output logic [SLICE_BITS-1:0]  o_alu_src0,
   output logic [SLICE_BITS-1:0]  o_alu_src1,
   output logic [SLICE_BITS-1:0]  o_alu_src2,
   output logic [SLICE_LANES-1:0] o_alu_exec,
   output logic [SLICE_LANES-1:0] o_alu_vcc,
   output logic                   o_alu_slice_valid,
   output logic [1:0]             o_alu_slice_idx,
   output logic                   o_dest_buffer_wr_en,
   output logic                   o_dest_buffer_shift_en,
   output logic                   o_wb_valid
);

   seq_state_e r_state, w_state_d;

   logic [VEC_BITS-1:0]    r_src0, r_src1, r_src2;
   logic [WF_LANES-1:0]    r_exec, r_vcc;
   logic [1:0]             r_slice_cnt;
   logic [2:0]             r_res_cnt;
   logic [SLICE_BITS-1:0]  r_alu_src0, r_alu_src1, r_alu_src2;
   logic [SLICE_LANES-1:0] r_alu_exec, r_alu_vcc;
   logic                   r_alu_valid;

   logic                   w_accept;
   logic                   w_present;
   logic                   w_pipe_out;
   logic [1:0]             w_next_idx;
   logic [SLICE_BITS-1:0]  w_slice_src0, w_slice_src1, w_slice_src2;
   logic [SLICE_LANES-1:0] w_slice_exec, w_slice_vcc;

   always_comb begin
      w_state_d = r_state;
      w_accept  = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_issue_valid) begin
               w_accept  = 1'b1;
               w_state_d = StIssue;
            end
         end
         StIssue: begin
            if (r_slice_cnt == LAST_SLICE) begin
               w_state_d = StDrain;
            end
         end
         StDrain: begin
            if (w_pipe_out && (r_res_cnt == 3'(LAST_SLICE))) begin
               w_state_d = StDone;
            end
         end
         StDone:  w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // Slice 0 is taken straight from the inputs so it is presented the cycle after accept.
   assign w_present  = w_accept | ((r_state == StIssue) && (r_slice_cnt != LAST_SLICE));
   assign w_next_idx = w_accept ? 2'd0 : r_slice_cnt + 2'd1;

   assign w_slice_src0 = vec_slice(w_accept ? i_src0_data : r_src0, w_next_idx);
   assign w_slice_src1 = vec_slice(w_accept ? i_src1_data : r_src1, w_next_idx);
   assign w_slice_src2 = vec_slice(w_accept ? i_src2_data : r_src2, w_next_idx);
   assign w_slice_exec = mask_slice(w_accept ? i_exec_value : r_exec, w_next_idx);
   assign w_slice_vcc  = mask_slice(w_accept ? i_vcc_value : r_vcc, w_next_idx);

   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_src0 <= i_src0_data;
         r_src1 <= i_src1_data;
         r_src2 <= i_src2_data;
         r_exec <= i_exec_value;
         r_vcc  <= i_vcc_value;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_slice_cnt <= 2'd0;
         r_res_cnt   <= 3'd0;
         r_alu_src0  <= '0;
         r_alu_src1  <= '0;
         r_alu_src2  <= '0;
         r_alu_exec  <= '0;
         r_alu_vcc   <= '0;
         r_alu_valid <= 1'b0;
      end else begin
         r_state <= w_state_d;
         if (w_present) begin
            r_alu_src0  <= w_slice_src0;
            r_alu_src1  <= w_slice_src1;
            r_alu_src2  <= w_slice_src2;
            r_alu_exec  <= w_slice_exec;
            r_alu_vcc   <= w_slice_vcc;
            r_alu_valid <= 1'b1;
            r_slice_cnt <= w_next_idx;
         end else if (r_state == StIssue) begin
            r_alu_src0  <= '0;
            r_alu_src1  <= '0;
            r_alu_src2  <= '0;
            r_alu_exec  <= '0;
            r_alu_vcc   <= '0;
            r_alu_valid <= 1'b0;
            r_slice_cnt <= 2'd0;
         end
         if (r_state == StDone) begin
            r_res_cnt <= 3'd0;
         end else if (w_pipe_out) begin
            r_res_cnt <= r_res_cnt + 3'd1;
         end
      end
   end

   slice_valid_pipe #(
      .DEPTH (ALU_LATENCY)
   ) u_valid_pipe (
      .i_clk   (i_clk),
      .i_clr   (i_rst),
      .i_valid (r_alu_valid),
      .o_valid (w_pipe_out)
   );

   assign o_issue_ready          = (r_state == StIdle);
   assign o_wb_valid             = (r_state == StDone);
   assign o_dest_buffer_wr_en    = w_pipe_out;
   assign o_dest_buffer_shift_en = w_pipe_out;
   assign o_alu_src0             = r_alu_src0;
   assign o_alu_src1             = r_alu_src1;
   assign o_alu_src2             = r_alu_src2;
   assign o_alu_exec             = r_alu_exec;
   assign o_alu_vcc              = r_alu_vcc;
   assign o_alu_slice_valid      = r_alu_valid;
   assign o_alu_slice_idx        = r_slice_cnt;

endmodule
